demux_wr_strobe: RTL

Parametrised successor to the fixed 1-to-8 row demux used in the 8x8 memory write path.
Accepts a write request (address, data, mode) over a valid/ready handshake and drives a registered one-hot row write-strobe bus plus a registered data bus.
Adds broadcast writes and a multi-cycle sweep mode that writes every row in turn.
Sits between the memory controller and the row array, replacing the combinational row-select demux.

---
 rtl/demux_wr_strobe_pkg.sv | 14 +
 rtl/demux_wr_strobe_if.sv | 14 +
 rtl/demux_wr_strobe_demux1ton.sv | 15 +
 rtl/demux_wr_strobe.sv | 121 ++++++++++++
 4 files changed

// File: rtl/demux_wr_strobe_pkg.sv
// Shared request-mode constants and FSM state encoding for the row write-strobe demux.
package demux_wr_strobe_pkg;

  localparam logic [1:0] MODE_SINGLE = 2'b00;
  localparam logic [1:0] MODE_BCAST  = 2'b01;
  localparam logic [1:0] MODE_SWEEP  = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/demux_wr_strobe_if.sv
// Write-request handshake between the memory controller (master) and the strobe demux (slave).
interface demux_wr_strobe_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_mode;
  logic [ADDR_W-1:0] req_adr;
  logic [DATA_W-1:0] req_data;

  modport master (output req_valid, req_mode, req_adr, req_data, input req_ready);
  modport slave  (input req_valid, req_mode, req_adr, req_data, output req_ready);
endinterface

// File: rtl/demux_wr_strobe_demux1ton.sv
// Combinational 1-to-N demux: routes inp onto the output bit selected by adr.
module demux1ton #(
  parameter int   ADDR_W = 3,
  localparam int  N      = 1 << ADDR_W
) (
  input  logic              inp,
  input  logic [ADDR_W-1:0] adr,
  output logic [N-1:0]      outp
);

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    assign outp[gi] = inp && (adr == ADDR_W'(gi));
  end

endmodule

// File: rtl/demux_wr_strobe.sv
// Registered row write-strobe generator: single, broadcast and sweep writes over a
// valid/ready request channel.
module demux_wr_strobe
  import demux_wr_strobe_pkg::*;
#(
  parameter int  ADDR_W = 3,
  parameter int  DATA_W = 8,
  localparam int N      = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  demux_wr_strobe_if.slave   req,
  output logic [N-1:0]       wr_sel,
  output logic [DATA_W-1:0]  wr_data,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]      sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [ADDR_W-1:0] dec_adr;
  logic [N-1:0]      dec_out;

  assign req.req_ready = (state_q == ST_IDLE) && !rst;
  assign accept        = req.req_valid && req.req_ready;

  // One decoder serves both paths: the sweep counter while sweeping, row 0 when a
  // sweep is being launched, otherwise the requested row.
  assign dec_adr = (state_q == ST_SWEEP)          ? cnt_q :
                   (req.req_mode == MODE_SWEEP)   ? '0    : req.req_adr;

  demux1ton #(.ADDR_W(ADDR_W)) u_dec (
    .inp  (1'b1),
    .adr  (dec_adr),
    .outp (dec_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = '0;
    data_d  = data_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          case (req.req_mode)
            MODE_SINGLE: begin
              sel_d  = dec_out;
              data_d = req.req_data;
            end
            MODE_BCAST: begin
              sel_d  = '1;
              data_d = req.req_data;
            end
            MODE_SWEEP: begin
              sel_d   = dec_out;
              data_d  = req.req_data;
              busy_d  = 1'b1;
              cnt_d   = ADDR_W'(1);
              state_d = ST_SWEEP;
            end
            default: err_d = 1'b1;
          endcase
        end
      end
      ST_SWEEP: begin
        sel_d  = dec_out;
        busy_d = 1'b1;
        // Terminal row compared explicitly so the counter never relies on wrapping.
        if (cnt_q == LAST_ROW) begin
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign wr_sel  = sel_q;
  assign wr_data = data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
